overlap_input_queue: RTL and testbench
======================================

Name: overlap_input_queue

Overview:
- Parametrised successor to the ADC-to-FFT input queue: buffers ADC samples in an inferred circular RAM and emits fixed-length AXI-Stream frames to the FFT.
- Adds a runtime-selectable hop (frame overlap), so frames may overlap by FRAME_LEN-hop samples.
- Adds parametrised sample width and depth, correct backpressure through the RAM read latency, a sticky overflow flag, a frame index on tuser, and occupancy status.
- Sits between the ADC sampler and the FFT IP's AXI-Stream slave.

Parameters:
- DATA_WIDTH, 12, sample width in bits.
- ADDR_WIDTH, 11, RAM address width; DEPTH = 2**ADDR_WIDTH.
- FRAME_LOG, 10, log2 of frame length; FRAME_LEN = 2**FRAME_LOG. Must satisfy FRAME_LOG <= ADDR_WIDTH.
- FIDX_WIDTH, 16, frame index counter width.

Ports:
- clock  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- adc_sample  in  DATA_WIDTH  sample from the ADC sampler
- adc_valid  in  1  one-cycle sample strobe; there is no backpressure to the ADC
- hop  in  FRAME_LOG+1  frame advance in samples; legal range 1..FRAME_LEN
- clear_overflow  in  1  clears the overflow flag
- m_data  out  DATA_WIDTH  AXI-Stream tdata
- m_valid  out  1  tvalid
- m_ready  in  1  tready
- m_last  out  1  tlast, asserted on the final sample of each frame
- m_user  out  FIDX_WIDTH  frame index of the current beat
- overflow  out  1  sticky flag: a sample was dropped
- fill  out  ADDR_WIDTH+1  samples held from the current frame base

Behaviour:
- Reset (synchronous, active low): base, fill, wr_ptr, rd_idx, frame_idx and overflow are all cleared; the output buffer and in-flight reads are flushed. Outputs after the reset edge: m_valid=0, m_last=0, m_user=0, m_data=0, overflow=0, fill=0. A reset mid-frame abandons the frame; no partial tlast is emitted.
- Write side:
  - On adc_valid with fill<DEPTH: RAM[wr_ptr]<=adc_sample, wr_ptr wraps mod DEPTH, fill+1.
  - On adc_valid with fill==DEPTH: the sample is dropped and overflow<=1. wr_ptr and fill are unchanged.
- Overflow flag: clear_overflow clears it. If a drop and clear_overflow occur in the same cycle, the set wins.
- Read FSM states IDLE and STREAM:
  - IDLE -> STREAM when fill>=FRAME_LEN. On the transition, latch hop_q = hop; a value of 0 or >FRAME_LEN is clamped to FRAME_LEN. rd_idx=0.
  - In STREAM, issue a read at address (base+rd_idx) mod DEPTH when (buffer entries + in-flight reads − same-cycle pop) < 2. Each issue increments rd_idx.
  - After issuing rd_idx==FRAME_LEN-1, return to IDLE.
  - When the last beat is accepted on the output: base += hop_q (mod DEPTH), fill -= hop_q, frame_idx+1 (wraps).
  - A simultaneous accepted write and frame retirement gives fill = fill - hop_q + 1.
  - IDLE may re-enter STREAM in the cycle after retirement. Reads of frame n+1 are not issued before frame n's last beat is retired.
- Overlap: samples in [base+hop_q, base+FRAME_LEN) stay resident and are re-read by the next frame. A changed hop input takes effect only at the next frame start.
- Read pipeline and latency:
  - RAM read latency is 1 cycle, followed by a 2-entry output buffer.
  - A write accepted at edge k that makes fill>=FRAME_LEN gives: FSM enters STREAM at edge k+1, first read issued in cycle k+1, m_valid=1 after edge k+3.
  - With m_ready held at 1, throughput is 1 beat/cycle within a frame.
- AXI rules:
  - While m_valid && !m_ready, m_data, m_last and m_user hold stable.
  - m_valid never drops without a handshake except on reset.
  - m_last is carried alongside its data through the pipeline.
- Read/write collision: a write never targets an address in [base, base+fill), so no RAM read-during-write hazard exists.

Decomposition:
- Shared package overlap_queue_pkg holds:
  - read FSM state encoding (IDLE, STREAM)
  - derived localparams DEPTH and FRAME_LEN
  - the hop clamp function
- One sub-module, stream_skid_buffer:
  - 2-entry AXI-Stream register buffer
  - payload {last, user, data}
  - exposes its occupancy for the read credit check
- RAM is inferred: single clock, one write port and one registered read port, with no vendor IP.

Test Plan:
1. DEPTH=16, FRAME_LEN=8, hop=8, m_ready=1, write samples 0..15 -> two frames, 0..7 (m_user=0) then 8..15 (m_user=1); m_last on values 7 and 15; fill returns to 0.
2. Same setup with hop=4, writing 0..15 -> frames 0..7, 4..11, 8..15 (m_user 0,1,2); fill=4 afterwards; no fourth frame until 4 more samples arrive.
3. Frame of values 0..7 with m_ready toggling 1,0,1,0 -> every value is delivered exactly once, in order; m_data is stable during stalls; exactly one m_last.
4. m_ready=0, write 17 samples with DEPTH=16 -> the 17th is dropped, overflow=1, fill=16; pulse clear_overflow -> overflow=0; a drop coinciding with clear leaves overflow=1.
5. hop=8 at frame start, change hop to 2 mid-frame -> the current frame retires with base+8; the next frame latches 2.
6. Assert reset_n=0 during beat 3 of a frame -> after the reset edge m_valid=0 and fill=0; new samples 100..107 produce a clean frame with m_user=0.

Source files
------------

// File: rtl/overlap_queue_pkg.sv
// Shared definitions for the overlapping ADC-to-FFT input queue.
package overlap_queue_pkg;

  typedef enum logic [0:0] {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_FRAME_LOG  = 10;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;
  localparam int DEF_FRAME_LEN  = 2 ** DEF_FRAME_LOG;

  // A hop of zero or beyond the frame length means "no overlap".
  function automatic logic hop_needs_clamp(input logic [31:0] hop, input logic [31:0] frame_len);
    logic result;
    if ((hop == 32'd0) || (hop > frame_len)) begin
      result = 1'b1;
    end else begin
      result = 1'b0;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry AXI-Stream register buffer; slot0 is always the presented beat.
module stream_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0_r;
  logic [WIDTH-1:0] slot1_r;
  logic [1:0]       count_r;
  logic             pop_s;

  assign pop_s     = (count_r != 2'd0) && out_ready;
  assign out_valid = (count_r != 2'd0);
  assign out_data  = slot0_r;
  assign count     = count_r;

  // Push/pop bookkeeping; the upstream credit check keeps pushes off a full buffer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot0_r <= {WIDTH{1'b0}};
      slot1_r <= {WIDTH{1'b0}};
      count_r <= 2'd0;
    end else begin
      case ({in_valid, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_r <= in_data;
          end else begin
            slot1_r <= in_data;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          slot0_r <= slot1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            slot0_r <= in_data;
          end else begin
            slot0_r <= slot1_r;
            slot1_r <= in_data;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/overlap_input_queue.sv
// ADC sample queue in a circular RAM, emitting overlapping fixed-length
// AXI-Stream frames with a frame index on tuser.
module overlap_input_queue
  import overlap_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 11,
  parameter int FRAME_LOG  = 10,
  parameter int FIDX_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] adc_sample,
  input  logic                  adc_valid,
  input  logic [FRAME_LOG:0]    hop,
  input  logic                  clear_overflow,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [FIDX_WIDTH-1:0] m_user,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   fill
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int FRAME_LEN = 2 ** FRAME_LOG;
  localparam int PAY_W     = 1 + FIDX_WIDTH + DATA_WIDTH;

  localparam logic [ADDR_WIDTH:0]   FULL_FILL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   FRAME_FILL = (ADDR_WIDTH+1)'(FRAME_LEN);
  localparam logic [FRAME_LOG:0]    HOP_MAX    = (FRAME_LOG+1)'(FRAME_LEN);
  localparam logic [FRAME_LOG-1:0]  LAST_IDX   = FRAME_LOG'(FRAME_LEN - 1);
  localparam logic [FRAME_LOG-1:0]  IDX_ONE    = FRAME_LOG'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH:0]   fill_r;
  logic [FRAME_LOG-1:0]  rd_idx_r;
  logic [FRAME_LOG:0]    hop_q_r;
  logic [FIDX_WIDTH-1:0] frame_idx_r;
  logic                  overflow_r;
  logic                  busy_r;
  rd_state_e             state_r;

  logic [DATA_WIDTH-1:0] ram_q_r;
  logic                  inflight_r;
  logic                  inflight_last_r;
  logic [FIDX_WIDTH-1:0] inflight_user_r;

  logic                  wr_en_s;
  logic                  drop_s;
  logic                  pop_s;
  logic                  retire_s;
  logic                  credit_s;
  logic                  rd_en_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic [ADDR_WIDTH:0]   hop_sub_s;
  logic [1:0]            sb_count_s;
  logic [PAY_W-1:0]      sb_out_s;

  assign wr_en_s   = adc_valid && (fill_r < FULL_FILL);
  assign drop_s    = adc_valid && (fill_r == FULL_FILL);
  assign pop_s     = m_valid && m_ready;
  assign retire_s  = pop_s && m_last;
  // Buffered beats plus the read in flight, less this cycle's pop, must leave a free slot.
  assign credit_s  = (({1'b0, sb_count_s} + {2'b00, inflight_r}) - {2'b00, pop_s}) < 3'd2;
  assign rd_en_s   = (state_r == RD_STREAM) && credit_s;
  assign rd_addr_s = base_r + ADDR_WIDTH'(rd_idx_r);
  assign hop_sub_s = retire_s ? (ADDR_WIDTH+1)'(hop_q_r) : {(ADDR_WIDTH+1){1'b0}};

  // Write pointer, occupancy, frame base and overflow flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
      base_r      <= {ADDR_WIDTH{1'b0}};
      fill_r      <= {(ADDR_WIDTH+1){1'b0}};
      frame_idx_r <= {FIDX_WIDTH{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
      end
      if (retire_s) begin
        base_r      <= base_r + ADDR_WIDTH'(hop_q_r);
        frame_idx_r <= frame_idx_r + FIDX_WIDTH'(1);
      end
      fill_r <= (fill_r - hop_sub_s) + {{ADDR_WIDTH{1'b0}}, wr_en_s};
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clear_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Read FSM; busy_r keeps the next frame waiting until the current one retires.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r  <= RD_IDLE;
      rd_idx_r <= {FRAME_LOG{1'b0}};
      hop_q_r  <= HOP_MAX;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        RD_IDLE: begin
          if ((fill_r >= FRAME_FILL) && !busy_r) begin
            state_r  <= RD_STREAM;
            rd_idx_r <= {FRAME_LOG{1'b0}};
            hop_q_r  <= hop_needs_clamp(32'(hop), 32'(FRAME_LEN)) ? HOP_MAX : hop;
            busy_r   <= 1'b1;
          end else if (retire_s) begin
            busy_r <= 1'b0;
          end
        end
        RD_STREAM: begin
          if (rd_en_s) begin
            rd_idx_r <= rd_idx_r + IDX_ONE;
            if (rd_idx_r == LAST_IDX) begin
              state_r <= RD_IDLE;
            end
          end
        end
        default: begin
          state_r <= RD_IDLE;
        end
      endcase
    end
  end

  // Inferred RAM: one write port, one registered read port.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= adc_sample;
    end
    if (rd_en_s) begin
      ram_q_r <= mem_r[rd_addr_s];
    end
  end

  // Sideband tags travel with the read so last/user align with their data.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      inflight_user_r <= {FIDX_WIDTH{1'b0}};
    end else begin
      inflight_r      <= rd_en_s;
      inflight_last_r <= (rd_idx_r == LAST_IDX);
      inflight_user_r <= frame_idx_r;
    end
  end

  stream_skid_buffer #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (inflight_r),
    .in_data   ({inflight_last_r, inflight_user_r, ram_q_r}),
    .out_valid (m_valid),
    .out_data  (sb_out_s),
    .out_ready (m_ready),
    .count     (sb_count_s)
  );

  assign m_last   = sb_out_s[PAY_W-1];
  assign m_user   = sb_out_s[DATA_WIDTH +: FIDX_WIDTH];
  assign m_data   = sb_out_s[DATA_WIDTH-1:0];
  assign overflow = overflow_r;
  assign fill     = fill_r;

endmodule

// File: tb/tb_overlap_input_queue.sv
// Self-checking bench for overlap_input_queue with DEPTH=16, FRAME_LEN=8.
module tb_overlap_input_queue;

  localparam int DW = 12;
  localparam int AW = 4;
  localparam int FL = 3;
  localparam int FW = 16;
  localparam int FLEN = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] adc_sample;
  logic          adc_valid;
  logic [FL:0]   hop;
  logic          clear_overflow;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [FW-1:0] m_user;
  logic          overflow;
  logic [AW:0]   fill;

  always #5 clock = ~clock;

  overlap_input_queue #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FRAME_LOG  (FL),
    .FIDX_WIDTH (FW)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .adc_sample     (adc_sample),
    .adc_valid      (adc_valid),
    .hop            (hop),
    .clear_overflow (clear_overflow),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .m_user         (m_user),
    .overflow       (overflow),
    .fill           (fill)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [FW-1:0] user;
  } beat_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] sample;
    logic          clr;
    logic          acc;
    logic          exp_ovf;
    logic [AW:0]   exp_fill;
  } vec_t;

  beat_t   exp_q[$];
  int      stream_q[$];
  int      model_base;
  int      model_fidx;
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  int      beats_seen = 0;
  int      first_valid_cyc = -1;
  int      beat_cycles[$];
  bit      mon_en = 1'b0;
  bit      prev_stall = 1'b0;
  beat_t   stall_beat;
  vec_t    vecs [0:20];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: whenever a full frame of samples is resident, queue its beats.
  task automatic model_push(input int v, input int hop_now);
    beat_t b;
    stream_q.push_back(v);
    while ((stream_q.size() - model_base) >= FLEN) begin
      for (int k = 0; k < FLEN; k++) begin
        b.data = DW'(stream_q[model_base + k]);
        b.last = (k == FLEN - 1);
        b.user = FW'(model_fidx);
        exp_q.push_back(b);
      end
      model_base += hop_now;
      model_fidx++;
    end
  endtask

  task automatic tick();
    if (mon_en) begin
      if (prev_stall) begin
        check("stall_valid", int'(m_valid), 1);
        check("stall_data", int'(m_data), int'(stall_beat.data));
        check("stall_last", int'(m_last), int'(stall_beat.last));
        check("stall_user", int'(m_user), int'(stall_beat.user));
      end
      if (m_valid && m_ready) begin
        beat_cycles.push_back(cyc);
        beats_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0d user %0d, expected no beat", m_data, m_user);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", int'(m_data), int'(e.data));
          check("beat_last", int'(m_last), int'(e.last));
          check("beat_user", int'(m_user), int'(e.user));
        end
      end
      prev_stall = m_valid && !m_ready;
      stall_beat.data = m_data;
      stall_beat.last = m_last;
      stall_beat.user = m_user;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (m_valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    adc_valid = 1'b0;
    clear_overflow = 1'b0;
    mon_en = 1'b0;
    tick();
    reset_n = 1'b1;
    mon_en = 1'b1;
    exp_q.delete();
    stream_q.delete();
    beat_cycles.delete();
    model_base = 0;
    model_fidx = 0;
    beats_seen = 0;
    first_valid_cyc = -1;
  endtask

  task automatic write(input int v);
    adc_sample = DW'(v);
    adc_valid = 1'b1;
    model_push(v, int'(hop));
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (exp_q.size() == 0) break;
      m_ready = toggle ? ((n % 2) == 0) : 1'b1;
      tick();
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    m_ready = 1'b1;
    for (int n = 0; n < 12; n++) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    adc_valid = 1'b0;
    adc_sample = '0;
    clear_overflow = 1'b0;
    m_ready = 1'b1;
    hop = 4'd8;
    @(posedge clock);
    #1;

    // Reset state
    do_reset();
    check("rst_valid", int'(m_valid), 0);
    check("rst_last", int'(m_last), 0);
    check("rst_user", int'(m_user), 0);
    check("rst_data", int'(m_data), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_fill", int'(fill), 0);

    // Test 1: hop=8, two back-to-back frames, latency and throughput
    begin
      int w8;
      w8 = 0;
      hop = 4'd8;
      for (int i = 0; i < 16; i++) begin
        write(i);
        if (i == 7) w8 = cyc;
      end
      check("t1_latency", first_valid_cyc - w8, 3);
      drain(1'b0, 200);
      check("t1_throughput", beat_cycles[7] - beat_cycles[0], 7);
      check("t1_fill", int'(fill), 0);
    end

    // Test 2: hop=4, overlapping frames and no premature fourth frame
    do_reset();
    hop = 4'd4;
    for (int i = 0; i < 16; i++) write(i);
    drain(1'b0, 200);
    check("t2_fill", int'(fill), 4);
    for (int n = 0; n < 10; n++) tick();
    check("t2_no_frame", int'(m_valid), 0);
    for (int i = 16; i < 20; i++) write(i);
    drain(1'b0, 200);
    check("t2_fill_after", int'(fill), 4);

    // Test 3: stalls with m_ready toggling
    do_reset();
    hop = 4'd8;
    for (int i = 0; i < 8; i++) write(i);
    drain(1'b1, 200);
    check("t3_fill", int'(fill), 0);

    // Test 4: overflow table, sink stalled
    do_reset();
    hop = 4'd8;
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) vecs[i] = '{1'b1, DW'(i), 1'b0, 1'b1, 1'b0, (AW+1)'(i + 1)};
    vecs[16] = '{1'b1, 12'd16, 1'b0, 1'b0, 1'b1, 5'd16};
    vecs[17] = '{1'b0, 12'd0,  1'b1, 1'b0, 1'b0, 5'd16};
    vecs[18] = '{1'b1, 12'd17, 1'b1, 1'b0, 1'b1, 5'd16};
    vecs[19] = '{1'b0, 12'd0,  1'b0, 1'b0, 1'b1, 5'd16};
    vecs[20] = '{1'b0, 12'd0,  1'b1, 1'b0, 1'b0, 5'd16};
    for (int r = 0; r < 21; r++) begin
      adc_valid = vecs[r].valid;
      adc_sample = vecs[r].sample;
      clear_overflow = vecs[r].clr;
      if (vecs[r].valid && vecs[r].acc) model_push(int'(vecs[r].sample), int'(hop));
      tick();
      adc_valid = 1'b0;
      clear_overflow = 1'b0;
      check("t4_ovf", int'(overflow), int'(vecs[r].exp_ovf));
      check("t4_fill", int'(fill), int'(vecs[r].exp_fill));
    end
    drain(1'b0, 200);
    check("t4_fill_drained", int'(fill), 0);

    // Test 5: hop changed mid-frame takes effect at the next frame
    do_reset();
    hop = 4'd8;
    for (int i = 0; i < 8; i++) write(i);
    tick();
    tick();
    hop = 4'd2;
    for (int i = 8; i < 16; i++) write(i);
    drain(1'b0, 200);
    check("t5_fill", int'(fill), 6);
    write(16);
    write(17);
    drain(1'b0, 200);
    check("t5_fill_after", int'(fill), 6);

    // Test 6: reset in the middle of a frame
    do_reset();
    hop = 4'd8;
    for (int i = 0; i < 8; i++) write(i);
    for (int n = 0; (n < 50) && (beats_seen < 3); n++) tick();
    check("t6_beats_before_reset", int'(beats_seen >= 3), 1);
    do_reset();
    check("t6_valid", int'(m_valid), 0);
    check("t6_fill", int'(fill), 0);
    check("t6_last", int'(m_last), 0);
    check("t6_user", int'(m_user), 0);
    for (int i = 100; i < 108; i++) write(i);
    drain(1'b0, 200);
    check("t6_fill_after", int'(fill), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
